uop_sequencer: RTL and testbench

- Sequences the decoded micro-op slots (up to three reg_load/select pairs per instruction) onto the shared ALU/register datapath, one slot per cycle.
- Generates the EIP advance after the last slot and holds off the fetch stage until the instruction retires.
- Sits between decode and the register file/ALU select logic, and honours a datapath stall for stack-memory accesses.

---
 rtl/uop_sequencer_if.sv | 35 +++
 rtl/uop_sequencer.sv | 140 ++++++++++++++
 tb/tb_uop_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uop_sequencer_if.sv
// Decode/datapath-facing signal bundle of the micro-op sequencer.
// The sequencer uses the slave modport; decode/datapath (or a bench) uses master.
interface uop_sequencer_if;
  logic       ope_valid;
  logic       ope_ready;
  logic [3:0] reg_load_1;
  logic [3:0] reg_load_2;
  logic [3:0] reg_load_3;
  logic [3:0] select_1;
  logic [3:0] select_2;
  logic [3:0] select_3;
  logic [3:0] num_of_ope;
  logic       stall;
  logic [3:0] alu_load;
  logic [3:0] alu_select;
  logic       load_en;
  logic [3:0] eip_inc;
  logic       eip_inc_en;
  logic       branch_taken;
  logic       halted;

  modport master (
    output ope_valid, reg_load_1, reg_load_2, reg_load_3,
           select_1, select_2, select_3, num_of_ope, stall,
    input  ope_ready, alu_load, alu_select, load_en,
           eip_inc, eip_inc_en, branch_taken, halted
  );

  modport slave (
    input  ope_valid, reg_load_1, reg_load_2, reg_load_3,
           select_1, select_2, select_3, num_of_ope, stall,
    output ope_ready, alu_load, alu_select, load_en,
           eip_inc, eip_inc_en, branch_taken, halted
  );
endinterface

// File: rtl/uop_sequencer.sv
// Issues up to three decoded reg_load/select slots per instruction, one per clk2, then advances EIP.
// Optional macro SINGLE_STEP_EN adds a step input that gates completion of the EIP-advance state.
module uop_sequencer #(
  parameter int         NUM_SLOTS = 3,
  parameter logic [3:0] REG_EIP   = 4'h4,
  parameter logic [3:0] REG_MAX   = 4'h6
) (
  input  logic clk2,
  input  logic reset_n,
`ifdef SINGLE_STEP_EN
  input  logic step,
`endif
  uop_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_EXEC1, S_EXEC2, S_EXEC3, S_ADV, S_HALT
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_load [3];
  logic [3:0] r_sel  [3];
  logic [3:0] r_num;
  logic [3:0] r_alu_load;
  logic [3:0] r_alu_sel;
  logic [3:0] r_eip_inc;
  logic       r_ew;
  logic       r_halted;
  logic [2:0] w_slot_v;
  logic       w_exec;
  logic       w_step;
  logic       w_ew_next;
  logic [1:0] w_cur;
  logic [1:0] w_nidx;
  logic [3:0] w_num;

  function automatic logic slot_valid(input int idx, input logic [3:0] code);
    return (idx < NUM_SLOTS) && (code != 4'd0) && (code <= REG_MAX);
  endfunction

  function automatic state_t idx2exec(input int idx);
    case (idx)
      0:       return S_EXEC1;
      1:       return S_EXEC2;
      default: return S_EXEC3;
    endcase
  endfunction

  // Lowest non-empty slot at or above 'from'; ADV when none remain.
  function automatic state_t first_exec(input logic [2:0] v, input int from);
    state_t s;
    s = S_ADV;
    for (int i = 2; i >= 0; i--)
      if (i >= from && v[i]) s = idx2exec(i);
    return s;
  endfunction

`ifdef SINGLE_STEP_EN
  assign w_step = step;
`else
  assign w_step = 1'b1;
`endif

  always_comb begin
    for (int i = 0; i < 3; i++) w_slot_v[i] = slot_valid(i, r_load[i]);
    w_exec = (r_state == S_EXEC1) || (r_state == S_EXEC2) || (r_state == S_EXEC3);
    case (r_state)
      S_EXEC2: w_cur = 2'd1;
      S_EXEC3: w_cur = 2'd2;
      default: w_cur = 2'd0;
    endcase
    // num_of_ope arrives one cycle after the handshake, so LATCH uses the live value.
    w_num     = (r_state == S_LATCH) ? bus.num_of_ope : r_num;
    w_ew_next = r_ew | (w_exec && (r_load[w_cur] == REG_EIP));
    w_next    = r_state;
    case (r_state)
      S_IDLE:  if (bus.ope_valid) w_next = S_LATCH;
      S_LATCH: w_next = (bus.num_of_ope == 4'd0) ? S_HALT : first_exec(w_slot_v, 0);
      S_EXEC1, S_EXEC2, S_EXEC3:
               if (!bus.stall) w_next = first_exec(w_slot_v, int'(w_cur) + 1);
      S_ADV:   if (w_step) w_next = S_IDLE;
      default: w_next = r_state;
    endcase
    case (w_next)
      S_EXEC2: w_nidx = 2'd1;
      S_EXEC3: w_nidx = 2'd2;
      default: w_nidx = 2'd0;
    endcase
  end

  always_ff @(posedge clk2 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      for (int i = 0; i < 3; i++) begin
        r_load[i] <= 4'd0;
        r_sel[i]  <= 4'd0;
      end
      r_num      <= 4'd0;
      r_alu_load <= 4'd0;
      r_alu_sel  <= 4'd0;
      r_eip_inc  <= 4'd0;
      r_ew       <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.ope_valid) begin
        r_load[0] <= bus.reg_load_1;
        r_load[1] <= bus.reg_load_2;
        r_load[2] <= bus.reg_load_3;
        r_sel[0]  <= bus.select_1;
        r_sel[1]  <= bus.select_2;
        r_sel[2]  <= bus.select_3;
        r_ew      <= 1'b0;
      end
      if (r_state == S_LATCH) begin
        r_num <= bus.num_of_ope;
        if (bus.num_of_ope == 4'd0) r_halted <= 1'b1;
      end
      if (w_exec) r_ew <= w_ew_next;
      // Slot codes are captured on entry so they stay stable across stall cycles.
      if (w_next != r_state &&
          (w_next == S_EXEC1 || w_next == S_EXEC2 || w_next == S_EXEC3)) begin
        r_alu_load <= r_load[w_nidx];
        r_alu_sel  <= r_sel[w_nidx];
      end
      if (w_next == S_ADV && r_state != S_ADV && !w_ew_next) r_eip_inc <= w_num;
    end
  end

  assign bus.ope_ready    = (r_state == S_IDLE);
  assign bus.alu_load     = r_alu_load;
  assign bus.alu_select   = r_alu_sel;
  assign bus.load_en      = w_exec & ~bus.stall;
  assign bus.eip_inc      = r_eip_inc;
  assign bus.eip_inc_en   = (r_state == S_ADV) & ~r_ew & w_step;
  assign bus.branch_taken = (r_state == S_ADV) &  r_ew & w_step;
  assign bus.halted       = r_halted;

endmodule

// File: tb/tb_uop_sequencer.sv
// Directed bench for uop_sequencer: slot and EIP-event scoreboards, stall, halt and reset-abort cases.
module tb_uop_sequencer;
  logic clk2 = 1'b0;
  logic reset_n;
`ifdef SINGLE_STEP_EN
  logic step;
`endif

  uop_sequencer_if bus ();

  uop_sequencer dut (
    .clk2    (clk2),
    .reset_n (reset_n),
`ifdef SINGLE_STEP_EN
    .step    (step),
`endif
    .bus     (bus)
  );

  always #5 clk2 = ~clk2;

  int checks = 0;
  int errors = 0;
  logic [7:0] q_load [$];
  logic [5:0] q_evt  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected events: {branch_taken, eip_inc_en, eip_inc when incrementing}.
  task automatic monitor();
    logic [7:0] e;
    logic [5:0] ev;
    if (bus.load_en === 1'b1) begin
      if (q_load.size() == 0) chk("load_unexpected", 32'(bus.load_en), 32'd0);
      else begin
        e = q_load.pop_front();
        chk("load_slot", 32'({bus.alu_load, bus.alu_select}), 32'(e));
      end
    end
    if (bus.eip_inc_en === 1'b1 || bus.branch_taken === 1'b1) begin
      if (q_evt.size() == 0) chk("eip_unexpected", 32'({bus.branch_taken, bus.eip_inc_en}), 32'd0);
      else begin
        ev = q_evt.pop_front();
        chk("eip_event",
            32'({bus.branch_taken, bus.eip_inc_en, (bus.eip_inc_en ? bus.eip_inc : 4'h0)}),
            32'(ev));
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk2);
    #2;
    monitor();
  endtask

  task automatic cyc_release();
    @(posedge clk2);
    #1 bus.stall = 1'b0;
    #1;
    monitor();
  endtask

  task automatic issue(input logic [3:0] l1, input logic [3:0] s1,
                       input logic [3:0] l2, input logic [3:0] s2,
                       input logic [3:0] l3, input logic [3:0] s3,
                       input logic [3:0] num, input bit exp_run);
    logic [3:0] ls [3];
    logic [3:0] ss [3];
    bit br;
    ls[0] = l1; ls[1] = l2; ls[2] = l3;
    ss[0] = s1; ss[1] = s2; ss[2] = s3;
    chk("ready_before_issue", 32'(bus.ope_ready), 32'd1);
    bus.reg_load_1 = l1; bus.select_1 = s1;
    bus.reg_load_2 = l2; bus.select_2 = s2;
    bus.reg_load_3 = l3; bus.select_3 = s3;
    bus.num_of_ope = num;
    bus.ope_valid  = 1'b1;
    if (exp_run) begin
      br = 1'b0;
      for (int i = 0; i < 3; i++)
        if (ls[i] != 4'd0 && ls[i] <= 4'd6) begin
          q_load.push_back({ls[i], ss[i]});
          if (ls[i] == 4'd4) br = 1'b1;
        end
      q_evt.push_back(br ? 6'b10_0000 : {2'b01, num});
    end
    cyc();
    bus.ope_valid = 1'b0;
    chk("ready_in_latch", 32'(bus.ope_ready), 32'd0);
  endtask

  task automatic wait_ready(input int max, output int n);
    n = 0;
    while (bus.ope_ready !== 1'b1 && n < max) begin
      cyc();
      n++;
    end
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_loads_left"}, 32'(q_load.size()), 32'd0);
    chk({tag, "_events_left"}, 32'(q_evt.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ready_seen;
    reset_n        = 1'b0;
    bus.ope_valid  = 1'b0;
    bus.reg_load_1 = 4'd0; bus.select_1 = 4'd0;
    bus.reg_load_2 = 4'd0; bus.select_2 = 4'd0;
    bus.reg_load_3 = 4'd0; bus.select_3 = 4'd0;
    bus.num_of_ope = 4'd0;
    bus.stall      = 1'b0;
`ifdef SINGLE_STEP_EN
    step = 1'b1;
`endif
    repeat (2) @(posedge clk2);
    #2;
    chk("rst_alu_load", 32'(bus.alu_load), 32'd0);
    chk("rst_alu_select", 32'(bus.alu_select), 32'd0);
    chk("rst_load_en", 32'(bus.load_en), 32'd0);
    chk("rst_eip_inc", 32'(bus.eip_inc), 32'd0);
    chk("rst_eip_inc_en", 32'(bus.eip_inc_en), 32'd0);
    chk("rst_branch", 32'(bus.branch_taken), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_ready", 32'(bus.ope_ready), 32'd1);
    reset_n = 1'b1;
    cyc();

    // push ebp
    issue(4'd1, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 1'b1);
    wait_ready(20, n);
    chk("push_latency", 32'(n), 32'd4);
    chk_empty("push");
    chk("push_eip_inc_hold", 32'(bus.eip_inc), 32'd1);

    // call: EIP written by slot 3
    issue(4'd1, 4'd2, 4'd1, 4'd3, 4'd4, 4'd2, 4'd5, 1'b1);
    wait_ready(20, n);
    chk("call_latency", 32'(n), 32'd5);
    chk_empty("call");
    chk("call_eip_inc_unchanged", 32'(bus.eip_inc), 32'd1);

    // mov eax,imm with 3 stall cycles
    issue(4'd3, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 1'b1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_alu_load", 32'(bus.alu_load), 32'd3);
      chk("stall_load_en", 32'(bus.load_en), 32'd0);
    end
    cyc_release();
    chk("stall_release_load_en", 32'(bus.load_en), 32'd1);
    wait_ready(20, n);
    chk("mov_tail_latency", 32'(n), 32'd2);
    chk_empty("mov");

    // num_of_ope == 0 halts
    issue(4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    bus.ope_valid = 1'b1;
    ready_seen = 0;
    repeat (20) begin
      cyc();
      if (bus.ope_ready !== 1'b0) ready_seen++;
    end
    chk("halt_ready_seen", 32'(ready_seen), 32'd0);
    chk("halt_flag", 32'(bus.halted), 32'd1);
    bus.ope_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("halt_async_clear", 32'(bus.halted), 32'd0);
    chk("halt_reset_ready", 32'(bus.ope_ready), 32'd1);
    cyc();
    reset_n = 1'b1;
    cyc();
    issue(4'd3, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 1'b1);
    wait_ready(20, n);
    chk("post_halt_latency", 32'(n), 32'd3);
    chk_empty("post_halt");

    // reset during EXEC2 of a 3-slot instruction
    issue(4'd1, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 1'b0);
    q_load.push_back({4'd1, 4'd2});
    q_load.push_back({4'd1, 4'd3});
    cyc();
    cyc();
    #1 reset_n = 1'b0;
    #1;
    chk("abort_load_en", 32'(bus.load_en), 32'd0);
    chk("abort_alu_load", 32'(bus.alu_load), 32'd0);
    chk("abort_alu_select", 32'(bus.alu_select), 32'd0);
    chk("abort_eip_inc", 32'(bus.eip_inc), 32'd0);
    cyc();
    reset_n = 1'b1;
    repeat (6) cyc();
    chk_empty("abort");
    issue(4'd1, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 1'b1);
    wait_ready(20, n);
    chk("push2_latency", 32'(n), 32'd4);
    chk_empty("push2");

`ifdef SINGLE_STEP_EN
    step = 1'b0;
    issue(4'd1, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 1'b1);
    cyc();
    cyc();
    repeat (3) begin
      cyc();
      chk("step_wait_inc_en", 32'(bus.eip_inc_en), 32'd0);
      chk("step_wait_ready", 32'(bus.ope_ready), 32'd0);
    end
    step = 1'b1;
    #1;
    monitor();
    chk("step_inc_en", 32'(bus.eip_inc_en), 32'd1);
    cyc();
    step = 1'b0;
    chk("step_done_ready", 32'(bus.ope_ready), 32'd1);
    chk("step_done_inc_en", 32'(bus.eip_inc_en), 32'd0);
    chk_empty("step");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
